debouncer_bank: RTL and testbench



---
 rtl/debouncer_bank.sv | 70 +++++++
 tb/tb_debouncer_bank.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debouncer_bank.sv
// N-channel debouncer: 2-FF sync, shared sample tick, STABLE_CNT agreeing ticks to flip state.
// Latency 2+(STABLE_CNT-1)*DIV+1 .. 2+STABLE_CNT*DIV+1 clk from pin edge; no backpressure, pulses are fire-and-forget.
module debouncer_bank #(
    parameter int N          = 4,
    parameter int DIV        = 65536,
    parameter int STABLE_CNT = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] pb_raw,
    output logic [N-1:0] pb_state,
    output logic [N-1:0] pb_down,
    output logic [N-1:0] pb_up,
    output logic         any_evt
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(STABLE_CNT + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CNT - 1);

    logic [N-1:0]  w_act;
    logic          w_tick;
    logic [PW-1:0] r_presc;
    logic [N-1:0]  r_sync1;
    logic [N-1:0]  r_sync2;
    logic [CW-1:0] r_cnt [N];

    // Normalise polarity before the synchroniser so reset value 0 means "released".
    assign w_act   = (ACTIVE_LOW != 0) ? ~pb_raw : pb_raw;
    assign w_tick  = (r_presc == PRESC_MAX);
    assign any_evt = |{pb_down, pb_up};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc  <= '0;
            r_sync1  <= '0;
            r_sync2  <= '0;
            pb_state <= '0;
            pb_down  <= '0;
            pb_up    <= '0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            r_sync1 <= w_act;
            r_sync2 <= r_sync1;
            pb_down <= '0;
            pb_up   <= '0;
            if (w_tick) begin
                for (int i = 0; i < N; i++) begin
                    if (r_sync2[i] == pb_state[i]) begin
                        r_cnt[i] <= '0;
                    end else if (r_cnt[i] == CNT_MAX) begin
                        // Final agreeing sample: commit the new level and emit its edge pulse.
                        r_cnt[i]    <= '0;
                        pb_state[i] <= r_sync2[i];
                        pb_down[i]  <= r_sync2[i];
                        pb_up[i]    <= ~r_sync2[i];
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_debouncer_bank.sv
// Bench for debouncer_bank: scoreboard of expected {pb_down,pb_up} events, consumed as pulses appear.
module tb_debouncer_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] pb_raw, pb_state, pb_down, pb_up;
    logic       any_evt;
    logic [3:0] pb_raw1, pb_state1, pb_down1, pb_up1;
    logic       any_evt1;

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int c_r     = 0;
    int n_evt   = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    debouncer_bank #(.N(4), .DIV(4), .STABLE_CNT(3), .ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .pb_raw(pb_raw), .pb_state(pb_state),
        .pb_down(pb_down), .pb_up(pb_up), .any_evt(any_evt)
    );

    debouncer_bank #(.N(4), .DIV(4), .STABLE_CNT(1), .ACTIVE_LOW(0)) dut1 (
        .clk(clk), .rst(rst), .pb_raw(pb_raw1), .pb_state(pb_state1),
        .pb_down(pb_down1), .pb_up(pb_up1), .any_evt(any_evt1)
    );

    // Advance one cycle, sample at negedge and consume any pulse against the scoreboard.
    task automatic step();
        logic [7:0] ev;
        logic [7:0] exp_v;
        @(negedge clk);
        cyc++;
        ev = {pb_down, pb_up};
        checks++;
        if (any_evt !== (|ev) || (pb_down & pb_up) !== 4'h0) begin
            errors++;
            $display("FAIL pulse_sanity cyc=%0d any_evt=%b down=%b up=%b", cyc, any_evt, pb_down, pb_up);
        end
        if (ev != 8'h0) begin
            n_evt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d got down=%b up=%b expected none", cyc, pb_down, pb_up);
            end else begin
                exp_v = exp_q.pop_front();
                if (ev !== exp_v) begin
                    errors++;
                    $display("FAIL event cyc=%0d got down=%b up=%b expected down=%b up=%b",
                             cyc, pb_down, pb_up, exp_v[7:4], exp_v[3:0]);
                end
            end
        end
    endtask

    task automatic wait_evt(input int budget, output int lat);
        int start_n;
        start_n = n_evt;
        lat = 0;
        while (n_evt == start_n && lat < budget) begin
            step();
            lat++;
        end
        if (n_evt == start_n) begin
            errors++;
            checks++;
            $display("FAIL event_timeout waited=%0d cycles, required a pulse", lat);
            lat = -1;
        end
    endtask

    task automatic test_reset();
        int lat;
        rst = 1'b1;
        pb_raw = 4'h0;
        pb_raw1 = 4'h0;
        repeat (3) begin
            step();
            checks++;
            if ({pb_state, pb_down, pb_up, any_evt} !== 13'h0) begin
                errors++;
                $display("FAIL reset_outputs state=%b down=%b up=%b any=%b required all 0",
                         pb_state, pb_down, pb_up, any_evt);
            end
        end
        exp_q.push_back({4'hF, 4'h0});
        rst = 1'b0;
        c_r = cyc;
        wait_evt(40, lat);
        checks++;
        if (lat < 11 || lat > 15) begin
            errors++;
            $display("FAIL reset_press_latency got=%0d required 11..15", lat);
        end
        checks++;
        if (pb_state !== 4'hF) begin
            errors++;
            $display("FAIL reset_press_state got=%b required 1111", pb_state);
        end
        step();
        checks++;
        if (pb_down !== 4'h0) begin
            errors++;
            $display("FAIL reset_press_width got=%b required 0000", pb_down);
        end
        pb_raw = 4'hF;
        exp_q.push_back({4'h0, 4'hF});
        wait_evt(40, lat);
        checks++;
        if (lat < 11 || lat > 15 || pb_state !== 4'h0) begin
            errors++;
            $display("FAIL release_all got lat=%0d state=%b required 11..15 and 0000", lat, pb_state);
        end
    endtask

    task automatic test_clean_press();
        int lat;
        pb_raw[0] = 1'b0;
        exp_q.push_back({4'h1, 4'h0});
        wait_evt(40, lat);
        checks++;
        if (lat < 11 || lat > 15) begin
            errors++;
            $display("FAIL press_latency got=%0d required 11..15", lat);
        end
        checks++;
        if (pb_state !== 4'h1) begin
            errors++;
            $display("FAIL press_state got=%b required 0001", pb_state);
        end
        step();
        checks++;
        if (pb_down !== 4'h0 || any_evt !== 1'b0) begin
            errors++;
            $display("FAIL press_width got down=%b any=%b required 0000 and 0", pb_down, any_evt);
        end
    endtask

    task automatic test_bounce();
        int lat;
        for (int i = 0; i < 10; i++) begin
            pb_raw[1] = ~pb_raw[1];
            repeat (3) step();
        end
        pb_raw[1] = 1'b0;
        exp_q.push_back({4'h2, 4'h0});
        wait_evt(40, lat);
        checks++;
        if (pb_state !== 4'h3) begin
            errors++;
            $display("FAIL bounce_state got=%b required 0011", pb_state);
        end
        repeat (20) step();
    endtask

    task automatic test_simultaneous();
        int lat;
        pb_raw[0] = 1'b1;
        pb_raw[2] = 1'b0;
        exp_q.push_back({4'h4, 4'h1});
        wait_evt(40, lat);
        checks++;
        if (pb_state !== 4'h6) begin
            errors++;
            $display("FAIL simul_state got=%b required 0110", pb_state);
        end
        step();
        checks++;
        if (any_evt !== 1'b0) begin
            errors++;
            $display("FAIL simul_any_width got=%b required 0", any_evt);
        end
    endtask

    task automatic test_reset_mid();
        int d, nt, k, lat;
        pb_raw[3] = 1'b0;
        d = cyc;
        nt = 0;
        k = 0;
        while (nt < 2 && k < 40) begin
            step();
            k++;
            if ((cyc - c_r) % 4 == 0 && cyc >= d + 3) nt++;
        end
        rst = 1'b1;
        step();
        checks++;
        if (pb_state !== 4'h0 || any_evt !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state got state=%b any=%b required 0000 and 0", pb_state, any_evt);
        end
        rst = 1'b0;
        c_r = cyc;
        exp_q.push_back({4'hE, 4'h0});
        wait_evt(40, lat);
        checks++;
        if (lat < 11 || lat > 15 || pb_state !== 4'hE) begin
            errors++;
            $display("FAIL mid_reset_relatch got lat=%0d state=%b required 11..15 and 1110", lat, pb_state);
        end
    endtask

    task automatic test_stable1();
        int k, n_up;
        pb_raw1[0] = 1'b1;
        k = 0;
        while (pb_down1[0] !== 1'b1 && k < 12) begin
            step();
            k++;
        end
        checks++;
        if (pb_down1[0] !== 1'b1 || k > 7 || any_evt1 !== 1'b1 || pb_state1 !== 4'h1) begin
            errors++;
            $display("FAIL sc1_press got lat=%0d down=%b any=%b state=%b required <=7, 0001, 1, 0001",
                     k, pb_down1, any_evt1, pb_state1);
        end
        k = 0;
        while ((cyc + 3 - c_r) % 4 != 2 && k < 8) begin
            step();
            k++;
        end
        pb_raw1[0] = 1'b0;
        step();
        pb_raw1[0] = 1'b1;
        n_up = 0;
        repeat (10) begin
            step();
            if (pb_up1 != 4'h0) n_up++;
        end
        checks++;
        if (n_up != 0 || pb_state1 !== 4'h1) begin
            errors++;
            $display("FAIL sc1_glitch got up_pulses=%0d state=%b required 0 and 0001", n_up, pb_state1);
        end
    endtask

    initial begin
        rst = 1'b1;
        pb_raw = 4'h0;
        pb_raw1 = 4'h0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_stable1();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
